// File: rtl/ym_ssg_pkg.sv
// rtl/ym_ssg_pkg.sv - SSG register map, reset values and shared types
package ym_ssg_pkg;

    localparam logic [7:0] REG_FREQ_A_L   = 8'h00;
    localparam logic [7:0] REG_FREQ_A_H   = 8'h01;
    localparam logic [7:0] REG_FREQ_B_L   = 8'h02;
    localparam logic [7:0] REG_FREQ_B_H   = 8'h03;
    localparam logic [7:0] REG_FREQ_C_L   = 8'h04;
    localparam logic [7:0] REG_FREQ_C_H   = 8'h05;
    localparam logic [7:0] REG_NOISE      = 8'h06;
    localparam logic [7:0] REG_ENABLE     = 8'h07;
    localparam logic [7:0] REG_VOL_A      = 8'h08;
    localparam logic [7:0] REG_VOL_B      = 8'h09;
    localparam logic [7:0] REG_VOL_C      = 8'h0A;
    localparam logic [7:0] REG_ENV_FREQ_L = 8'h0B;
    localparam logic [7:0] REG_ENV_FREQ_H = 8'h0C;
    localparam logic [7:0] REG_ENV_SHAPE  = 8'h0D;

    localparam int BUSY_CYCLES_DEFAULT = 32;

    localparam logic [5:0] EN_RESET = 6'h3F;

    typedef struct packed {
        logic [11:0] freq_a;
        logic [11:0] freq_b;
        logic [11:0] freq_c;
        logic [4:0]  noise;
        logic [5:0]  en;
        logic [4:0]  vol_a;
        logic [4:0]  vol_b;
        logic [4:0]  vol_c;
        logic [15:0] env_freq;
        logic [3:0]  env;
    } ssg_regs_t;

    localparam ssg_regs_t REGS_RESET = '{
        freq_a:   12'h000,
        freq_b:   12'h000,
        freq_c:   12'h000,
        noise:    5'h00,
        en:       EN_RESET,
        vol_a:    5'h00,
        vol_b:    5'h00,
        vol_c:    5'h00,
        env_freq: 16'h0000,
        env:      4'h0
    };

    function automatic logic reg_valid(input logic [7:0] a);
        return a <= REG_ENV_SHAPE;
    endfunction

endpackage

// File: rtl/ym_ssg_regs_if.sv
// rtl/ym_ssg_regs_if.sv - CPU bus of the SSG register block
interface ym_ssg_regs_if;
    logic       nCS;
    logic       nWR;
    logic       nRD;
    logic       A0;
    logic [7:0] DIN;
    logic [7:0] DOUT;

    modport master (output nCS, nWR, nRD, A0, DIN, input  DOUT);
    modport slave  (input  nCS, nWR, nRD, A0, DIN, output DOUT);
endinterface

// File: rtl/ym_strobe_sync.sv
// rtl/ym_strobe_sync.sv - 2-flop strobe synchroniser with edge detection
module ym_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic level_n,
    output logic rise
);
    logic s1, s2, s3;
    logic primed;
    logic idle_seen;
    logic armed;
    logic fall_det;
    logic rise_det;

    assign fall_det = ~s2 & s3;
    assign rise_det = s2 & ~s3;
    assign level_n  = s2;
    assign rise     = rise_det & armed;

    // A rise only counts if its strobe went low after idle was observed post-reset,
    // so a strobe already active across reset never commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            primed    <= 1'b0;
            idle_seen <= 1'b0;
            armed     <= 1'b0;
        end else begin
            s1     <= strobe_n;
            s2     <= s1;
            s3     <= s2;
            primed <= 1'b1;
            if (primed && s1)
                idle_seen <= 1'b1;
            if (fall_det)
                armed <= idle_seen;
            else if (rise_det)
                armed <= 1'b0;
        end
    end
endmodule

// File: rtl/ym_ssg_regs.sv
// rtl/ym_ssg_regs.sv - SSG register file with CPU bus, busy flag and read-back
// Optional register read-back is enabled by defining YM_SSG_READBACK_EN.
module ym_ssg_regs
    import ym_ssg_pkg::*;
#(
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEFAULT
) (
    input  logic         PHI_S,
    input  logic         nRESET,
    ym_ssg_regs_if.slave bus,
    output logic [11:0]  SSG_FREQ_A,
    output logic [11:0]  SSG_FREQ_B,
    output logic [11:0]  SSG_FREQ_C,
    output logic [4:0]   SSG_NOISE,
    output logic [5:0]   SSG_EN,
    output logic [4:0]   SSG_VOL_A,
    output logic [4:0]   SSG_VOL_B,
    output logic [4:0]   SSG_VOL_C,
    output logic [15:0]  SSG_ENV_FREQ,
    output logic [3:0]   SSG_ENV,
    output logic         ENV_RESTART
);
    localparam logic [5:0] BUSY_LOAD = 6'(BUSY_CYCLES);

    logic       wr_n, wr_rise;
    logic       rd_n, rd_rise;
    logic       unused_rd_rise;
    ssg_regs_t  regs;
    logic [7:0] addr;
    logic       cap_a0;
    logic [7:0] cap_din;
    logic [5:0] busy_cnt;
    logic       busy;
    logic       env_restart;
    logic [7:0] dout;
    logic [7:0] rd_value;

    ym_strobe_sync u_wr_sync (
        .clk      (PHI_S),
        .rst_n    (nRESET),
        .strobe_n (bus.nCS | bus.nWR),
        .level_n  (wr_n),
        .rise     (wr_rise)
    );

    ym_strobe_sync u_rd_sync (
        .clk      (PHI_S),
        .rst_n    (nRESET),
        .strobe_n (bus.nCS | bus.nRD),
        .level_n  (rd_n),
        .rise     (rd_rise)
    );

    assign unused_rd_rise = rd_rise;
    assign busy           = busy_cnt != 6'd0;

`ifdef YM_SSG_READBACK_EN
    function automatic logic [7:0] reg_read(input ssg_regs_t r, input logic [7:0] a);
        case (a)
            REG_FREQ_A_L:   return r.freq_a[7:0];
            REG_FREQ_A_H:   return {4'h0, r.freq_a[11:8]};
            REG_FREQ_B_L:   return r.freq_b[7:0];
            REG_FREQ_B_H:   return {4'h0, r.freq_b[11:8]};
            REG_FREQ_C_L:   return r.freq_c[7:0];
            REG_FREQ_C_H:   return {4'h0, r.freq_c[11:8]};
            REG_NOISE:      return {3'h0, r.noise};
            REG_ENABLE:     return {2'h0, r.en};
            REG_VOL_A:      return {3'h0, r.vol_a};
            REG_VOL_B:      return {3'h0, r.vol_b};
            REG_VOL_C:      return {3'h0, r.vol_c};
            REG_ENV_FREQ_L: return r.env_freq[7:0];
            REG_ENV_FREQ_H: return r.env_freq[15:8];
            REG_ENV_SHAPE:  return {4'h0, r.env};
            default:        return 8'h00;
        endcase
    endfunction

    always_comb begin
        rd_value = {busy, 7'b0};
        if (bus.A0)
            rd_value = reg_read(regs, addr);
    end
`else
    always_comb begin
        rd_value = {busy, 7'b0};
        if (bus.A0)
            rd_value = 8'h00;
    end
`endif

    always_ff @(posedge PHI_S or negedge nRESET) begin
        if (!nRESET) begin
            regs        <= REGS_RESET;
            addr        <= 8'h00;
            cap_a0      <= 1'b0;
            cap_din     <= 8'h00;
            busy_cnt    <= 6'd0;
            env_restart <= 1'b0;
            dout        <= 8'h00;
        end else begin
            env_restart <= 1'b0;
            if (!wr_n) begin
                cap_a0  <= bus.A0;
                cap_din <= bus.DIN;
            end
            if (busy)
                busy_cnt <= busy_cnt - 6'd1;
            if (wr_rise) begin
                if (!cap_a0) begin
                    addr <= cap_din;
                end else if (reg_valid(addr)) begin
                    busy_cnt <= BUSY_LOAD;
                    case (addr)
                        REG_FREQ_A_L:   regs.freq_a[7:0]    <= cap_din;
                        REG_FREQ_A_H:   regs.freq_a[11:8]   <= cap_din[3:0];
                        REG_FREQ_B_L:   regs.freq_b[7:0]    <= cap_din;
                        REG_FREQ_B_H:   regs.freq_b[11:8]   <= cap_din[3:0];
                        REG_FREQ_C_L:   regs.freq_c[7:0]    <= cap_din;
                        REG_FREQ_C_H:   regs.freq_c[11:8]   <= cap_din[3:0];
                        REG_NOISE:      regs.noise          <= cap_din[4:0];
                        REG_ENABLE:     regs.en             <= cap_din[5:0];
                        REG_VOL_A:      regs.vol_a          <= cap_din[4:0];
                        REG_VOL_B:      regs.vol_b          <= cap_din[4:0];
                        REG_VOL_C:      regs.vol_c          <= cap_din[4:0];
                        REG_ENV_FREQ_L: regs.env_freq[7:0]  <= cap_din;
                        REG_ENV_FREQ_H: regs.env_freq[15:8] <= cap_din;
                        REG_ENV_SHAPE: begin
                            regs.env    <= cap_din[3:0];
                            env_restart <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            // A concurrent write strobe wins: the read bus stays quiet.
            dout <= (!rd_n && wr_n) ? rd_value : 8'h00;
        end
    end

    assign bus.DOUT     = dout;
    assign SSG_FREQ_A   = regs.freq_a;
    assign SSG_FREQ_B   = regs.freq_b;
    assign SSG_FREQ_C   = regs.freq_c;
    assign SSG_NOISE    = regs.noise;
    assign SSG_EN       = regs.en;
    assign SSG_VOL_A    = regs.vol_a;
    assign SSG_VOL_B    = regs.vol_b;
    assign SSG_VOL_C    = regs.vol_c;
    assign SSG_ENV_FREQ = regs.env_freq;
    assign SSG_ENV      = regs.env;
    assign ENV_RESTART  = env_restart;
endmodule
